dcache_ctrl: RTL and testbench

//   Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.

---
 rtl/dcache_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl
//   Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
//   A read hit returns data combinationally in the same cycle; a read miss fills
//   the whole line from main memory one word at a time; every store is written
//   through to main memory, and a store that hits also updates the cached word.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   mem_read, mem_write    MEM-stage load / store request (store wins if both)
//   addr, write_data       byte address (word access, [1:0] ignored), store data
//   read_data              load data, valid while data_hit=1 and mem_read=1
//   data_hit               1 = access complete or no access; 0 = stall pipeline
//   mm_req, mm_we          main-memory request (held until mm_ready), 1 = write
//   mm_addr, mm_wdata      main-memory word address / write data
//   mm_rdata, mm_ready     main-memory read data / one-cycle completion strobe
module dcache_ctrl #(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        data_hit,
  output logic        mm_req,
  output logic        mm_we,
  output logic [31:0] mm_addr,
  output logic [31:0] mm_wdata,
  input  logic [31:0] mm_rdata,
  input  logic        mm_ready
);

  localparam int IW = $clog2(NUM_LINES);
  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int TW = 32 - IW - OW - 2;
  localparam logic [OW-1:0] LAST_WORD = OW'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} state_t;

  state_t state, state_nxt;

  logic [NUM_LINES-1:0] valid_q;
  logic [TW-1:0]        tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES][WORDS_PER_LINE];
  logic [OW-1:0]        word_cnt;

  // Access captured in IDLE; drives the fill/write-through while inputs are held.
  logic [31:2] lat_addr;
  logic [31:0] lat_wdata;

  logic [OW-1:0] in_off, lat_off;
  logic [IW-1:0] in_idx, lat_idx;
  logic [TW-1:0] in_tag, lat_tag;
  logic          in_hit, lat_hit;
  logic          unused_addr_lsbs;

  assign in_off  = addr[OW+1:2];
  assign in_idx  = addr[OW+IW+1:OW+2];
  assign in_tag  = addr[31:OW+IW+2];
  assign lat_off = lat_addr[OW+1:2];
  assign lat_idx = lat_addr[OW+IW+1:OW+2];
  assign lat_tag = lat_addr[31:OW+IW+2];

  assign unused_addr_lsbs = ^addr[1:0];

  assign in_hit  = valid_q[in_idx]  && (tag_q[in_idx]  == in_tag);
  assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

  // Combinational array read: a hit costs no extra cycle.
  assign read_data = data_q[in_idx][in_off];

  always_comb begin
    state_nxt = state;
    data_hit  = 1'b1;
    mm_req    = 1'b0;
    mm_we     = 1'b0;
    mm_addr   = 32'h0;
    mm_wdata  = lat_wdata;
    case (state)
      IDLE: begin
        if (mem_write) begin
          data_hit  = 1'b0;
          state_nxt = WRITE;
        end else if (mem_read && !in_hit) begin
          data_hit  = 1'b0;
          state_nxt = FILL;
        end
      end
      FILL: begin
        data_hit = 1'b0;
        mm_req   = 1'b1;
        mm_addr  = {lat_tag, lat_idx, word_cnt, 2'b00};
        if (mm_ready && (word_cnt == LAST_WORD)) state_nxt = IDLE;
      end
      WRITE: begin
        data_hit = 1'b0;
        mm_req   = 1'b1;
        mm_we    = 1'b1;
        mm_addr  = {lat_addr, 2'b00};
        if (mm_ready) state_nxt = WDONE;
      end
      WDONE: begin
        // One-cycle completion so the requester advances past the store.
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, line valid bits, fill word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      valid_q  <= '0;
      word_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          // Invalidate on fill entry so a partially filled line never hits.
          if (!mem_write && mem_read && !in_hit) begin
            valid_q[in_idx] <= 1'b0;
            word_cnt        <= '0;
          end
        end
        FILL: begin
          if (mm_ready) begin
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == LAST_WORD) valid_q[lat_idx] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath state: latched access, tag and data arrays (not reset).
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (mem_read || mem_write) begin
          lat_addr  <= addr[31:2];
          lat_wdata <= write_data;
        end
      end
      FILL: begin
        if (mm_ready) begin
          data_q[lat_idx][word_cnt] <= mm_rdata;
          if (word_cnt == LAST_WORD) tag_q[lat_idx] <= lat_tag;
        end
      end
      WRITE: begin
        // No allocation on a store miss: only a resident line is updated.
        if (mm_ready && lat_hit) data_q[lat_idx][lat_off] <= lat_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] addr, write_data;
  logic [31:0] read_data;
  logic        data_hit;
  logic        mm_req, mm_we;
  logic [31:0] mm_addr, mm_wdata;
  logic [31:0] mm_rdata;
  logic        mm_ready;

  dcache_ctrl #(.NUM_LINES(16), .WORDS_PER_LINE(4)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .write_data(write_data),
    .read_data(read_data), .data_hit(data_hit),
    .mm_req(mm_req), .mm_we(mm_we), .mm_addr(mm_addr), .mm_wdata(mm_wdata),
    .mm_rdata(mm_rdata), .mm_ready(mm_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    bit          hit;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mmx_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  mmx_t mm_q[$];

  // Reference model: line presence per index plus a flat view of memory.
  bit          m_valid [16];
  logic [23:0] m_tag   [16];
  logic [31:0] ref_mem [logic [31:0]];
  // Main memory seen by the DUT.
  logic [31:0] mm_mem  [logic [31:0]];

  int fixed_lat = 0;
  int cur_lat   = 1;
  int cnt       = 0;
  int req_acc   = 0;
  int stall     = 0;
  int hs_cnt    = 0;
  bit done      = 0;

  function automatic logic [31:0] init_val(input logic [31:0] w);
    return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : init_val(w);
  endfunction

  function automatic logic [31:0] mm_rd(input logic [31:0] w);
    return mm_mem.exists(w) ? mm_mem[w] : init_val(w);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Main-memory responder followed by the access monitor / scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      mm_ready = 1'b0;
      cnt      = 0;
      stall    = 0;
      req_acc  = 0;
    end else begin
      if (mm_ready) begin
        mm_ready = 1'b0;
        cnt      = 0;
      end
      if (mm_req) begin
        if (cnt == 0) cur_lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
        cnt++;
        req_acc++;
        if (cnt >= cur_lat) begin
          mmx_t m;
          mm_ready = 1'b1;
          hs_cnt++;
          if (mm_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_mm_req actual=%h expected=none", mm_addr);
          end else begin
            m = mm_q.pop_front();
            chk("mm_we", {31'h0, mm_we}, {31'h0, m.we});
            chk("mm_addr", mm_addr, m.addr);
            if (m.we) chk("mm_wdata", mm_wdata, m.wdata);
          end
          if (mm_we) mm_mem[mm_addr] = mm_wdata;
          else       mm_rdata = mm_rd(mm_addr);
        end
      end

      if (mem_read || mem_write) begin
        if (data_hit) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_completion actual=%h expected=none", addr);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stall_cycles", stall, e.hit ? 32'd0 : 32'(req_acc + 1));
            if (!e.wr) chk("read_data", read_data, e.data);
          end
          done    = 1'b1;
          stall   = 0;
          req_acc = 0;
        end else begin
          stall++;
        end
      end else begin
        chk("idle_data_hit", {31'h0, data_hit}, 32'd1);
        chk("idle_mm_req", {31'h0, mm_req}, 32'd0);
      end
    end
  end

  task automatic start(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    mmx_t        m;
    logic [31:0] w;
    logic [3:0]  idx;
    logic [23:0] tg;
    w   = {a[31:2], 2'b00};
    idx = a[7:4];
    tg  = a[31:8];
    if (wr) begin
      e.wr = 1; e.hit = 0; e.data = 32'h0;
      m.we = 1; m.addr = w; m.wdata = wd;
      mm_q.push_back(m);
      ref_mem[w] = wd;
    end else begin
      e.wr  = 0;
      e.hit = m_valid[idx] && (m_tag[idx] == tg);
      if (!e.hit) begin
        for (int k = 0; k < 4; k++) begin
          logic [1:0] kk;
          kk = k[1:0];
          m.we = 0; m.addr = {a[31:4], kk, 2'b00}; m.wdata = 32'h0;
          mm_q.push_back(m);
        end
        m_valid[idx] = 1;
        m_tag[idx]   = tg;
      end
      e.data = ref_rd(w);
    end
    exp_q.push_back(e);
    done       = 1'b0;
    mem_read   = rd;
    mem_write  = wr;
    addr       = a;
    write_data = wd;
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (!done && c < 400) begin
      @(posedge clk);
      c++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL access_timeout actual=pending expected=complete addr=%h", addr);
      finish_run();
    end
    #1;
  endtask

  task automatic access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] wd);
    start(wr, rd, a, wd);
    wait_done();
  endtask

  task automatic idle(input int n);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 0;
    exp_q.delete();
    mm_q.delete();
  endtask

  initial begin
    logic [23:0] tags [4];
    tags[0] = 24'h0; tags[1] = 24'h1; tags[2] = 24'h2; tags[3] = 24'h20;

    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    addr = 32'h0; write_data = 32'h0; mm_rdata = 32'h0; mm_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_data_hit", {31'h0, data_hit}, 32'd1);
    chk("reset_mm_req", {31'h0, mm_req}, 32'd0);
    chk("reset_mm_we", {31'h0, mm_we}, 32'd0);
    @(posedge clk); #1;

    // Cold read miss with a fixed memory latency, then a same-line hit.
    fixed_lat = 3;
    access(0, 1, 32'h0000_0100, 32'h0);
    access(0, 1, 32'h0000_0104, 32'h0);
    // Store hit then read back; store miss then read (no allocate).
    access(1, 0, 32'h0000_0108, 32'hDEADBEEF);
    access(0, 1, 32'h0000_0108, 32'h0);
    access(1, 0, 32'h0000_2000, 32'h1234_5678);
    access(0, 1, 32'h0000_2000, 32'h0);
    // Conflicting lines on index 0.
    access(0, 1, 32'h0000_0100, 32'h0);
    access(0, 1, 32'h0000_0200, 32'h0);
    access(0, 1, 32'h0000_0100, 32'h0);
    // Load and store together: the store wins.
    access(1, 1, 32'h0000_010C, 32'hCAFE_F00D);
    access(0, 1, 32'h0000_010C, 32'h0);
    idle(2);

    // Reset during the third word of a fill.
    fixed_lat = 2;
    hs_cnt = 0;
    start(0, 1, 32'h0000_0200, 32'h0);
    begin
      int c;
      c = 0;
      while (hs_cnt < 2 && c < 100) begin
        @(posedge clk);
        c++;
      end
      if (hs_cnt < 2) begin
        checks++;
        failures++;
        $display("FAIL fill_progress_timeout actual=%0d expected=2", hs_cnt);
        finish_run();
      end
    end
    #1;
    rst = 1'b1; mem_read = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_mm_req", {31'h0, mm_req}, 32'd0);
    chk("abort_data_hit", {31'h0, data_hit}, 32'd1);
    @(posedge clk); #1;
    access(0, 1, 32'h0000_0200, 32'h0);
    access(0, 1, 32'h0000_0208, 32'h0);

    // Randomized traffic with random memory latency.
    fixed_lat = 0;
    for (int n = 0; n < 250; n++) begin
      int          op;
      logic [3:0]  idx;
      logic [1:0]  off;
      logic [23:0] tg;
      logic [31:0] a;
      op  = $urandom_range(0, 9);
      idx = 4'($urandom_range(0, 15));
      off = 2'($urandom_range(0, 3));
      tg  = tags[$urandom_range(0, 3)];
      a   = {tg, idx, off, 2'b00};
      if (op == 0)      access(1, 1, a, $urandom);
      else if (op < 4)  access(1, 0, a, $urandom);
      else              access(0, 1, a, 32'h0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(3);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("mm_q_drained", mm_q.size(), 32'd0);
    finish_run();
  end

endmodule
